// File: rtl/sal_bk_pkg.sv
// Shared command/state encodings for the per-bank DDR2 tracker.
package sal_bk_pkg;

  localparam int unsigned BK_CMD_W = 3;

  typedef enum logic [BK_CMD_W-1:0] {
    NOP = 3'd0,
    ACT = 3'd1,
    RD  = 3'd2,
    WR  = 3'd3,
    PRE = 3'd4,
    REF = 3'd5
  } bk_cmd_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACTIVE      = 2'd1,
    PRECHARGING = 2'd2,
    REFRESHING  = 2'd3
  } bk_state_t;

endpackage

// File: rtl/sal_bk_timing_intf.sv
// Bank timing values (in clk cycles) driven by the configuration block.
interface sal_bk_timing_intf #(
  parameter int unsigned TIMING_W = 8
);
  logic [TIMING_W-1:0] t_rcd;
  logic [TIMING_W-1:0] t_rp;
  logic [TIMING_W-1:0] t_ras;
  logic [TIMING_W-1:0] t_rfc;
  logic [TIMING_W-1:0] t_rtp;
  logic [TIMING_W-1:0] t_wtp;

  modport cfg  (output t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp);
  modport bank (input  t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp);
endinterface

// File: rtl/sal_bk_tcnt.sv
// Saturating down-counter loaded with max(t,1)-1; optional max-merge with the running count.
module sal_bk_tcnt #(
  parameter int unsigned TIMING_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                merge,
  input  logic [TIMING_W-1:0] t,
  output logic [TIMING_W-1:0] cnt,
  output logic                is_zero
);

  logic [TIMING_W-1:0] dec_c;
  logic [TIMING_W-1:0] ld_c;
  logic [TIMING_W-1:0] nxt_c;

  // Merge compares against the decremented value so a longer pending window is never cut short.
  always_comb begin
    dec_c = (cnt == '0) ? '0 : cnt - TIMING_W'(1);
    ld_c  = (t == '0) ? '0 : t - TIMING_W'(1);
    nxt_c = dec_c;
    if (load) begin
      nxt_c = (merge && (dec_c > ld_c)) ? dec_c : ld_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      is_zero <= 1'b1;
    end else begin
      cnt     <= nxt_c;
      is_zero <= (nxt_c == '0);
    end
  end

endmodule

// File: rtl/sal_bank_ctrl.sv
// Per-bank DDR2 state tracker and timing guard between scheduler and command bus.
// Define SAL_BK_CMD_ERR_EN to add the sticky cmd_err illegal-command flag.
module sal_bank_ctrl
  import sal_bk_pkg::*;
#(
  parameter int unsigned ROW_W    = 14,
  parameter int unsigned TIMING_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sal_bk_timing_intf.bank     bk_timing_intf,
  input  logic                cmd_valid,
  input  logic [BK_CMD_W-1:0] cmd,
  input  logic [ROW_W-1:0]    cmd_row,
  output logic                cmd_ready,
  output logic                act_ready,
  output logic                rdwr_ready,
  output logic                pre_ready,
  output logic                ref_ready,
  output logic                row_open,
  output logic [ROW_W-1:0]    open_row
`ifdef SAL_BK_CMD_ERR_EN
  ,
  output logic                cmd_err
`endif
);

  bk_state_t state_q;
  bk_state_t state_nxt;
  bk_cmd_t   cmd_e;

  logic legal_c;
  logic row_hit_c;
  logic acc_act, acc_rd, acc_wr, acc_pre, acc_ref;
  logic rcd_z, ras_z, rtp_z, rp_z, rfc_z;
  logic [TIMING_W-1:0] rcd_cnt, ras_cnt, rtp_cnt, rp_cnt, rfc_cnt;
  logic [TIMING_W-1:0] rtp_t_c;

  assign cmd_e = bk_cmd_t'(cmd);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Leave PRECHARGING/REFRESHING on the edge the counter reaches 0, so IDLE coincides with rp/rfc expiry.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (acc_act)      state_nxt = ACTIVE;
        else if (acc_ref) state_nxt = (bk_timing_intf.t_rfc <= TIMING_W'(1)) ? IDLE : REFRESHING;
      end
      ACTIVE: begin
        if (acc_pre)      state_nxt = (bk_timing_intf.t_rp <= TIMING_W'(1)) ? IDLE : PRECHARGING;
      end
      PRECHARGING: if (rp_cnt <= TIMING_W'(1)) state_nxt = IDLE;
      REFRESHING:  if (rfc_cnt <= TIMING_W'(1)) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Readiness lookahead, legality and acceptance.
  always_comb begin
    act_ready  = (state_q == IDLE) && rp_z && rfc_z;
    ref_ready  = (state_q == IDLE) && rp_z && rfc_z;
    rdwr_ready = (state_q == ACTIVE) && rcd_z;
    pre_ready  = (state_q == ACTIVE) && ras_z && rtp_z;
    row_hit_c  = (cmd_row == open_row);
    legal_c    = 1'b0;
    cmd_ready  = 1'b0;
    case (cmd_e)
      NOP: legal_c = 1'b1;
      ACT, REF: begin
        legal_c   = (state_q == IDLE);
        cmd_ready = cmd_valid && act_ready;
      end
      RD, WR: begin
        legal_c   = (state_q == ACTIVE) && row_hit_c;
        cmd_ready = cmd_valid && rdwr_ready && row_hit_c;
      end
      PRE: begin
        legal_c   = (state_q == ACTIVE);
        cmd_ready = cmd_valid && pre_ready;
      end
      default: legal_c = 1'b0;
    endcase
    acc_act = cmd_ready && (cmd_e == ACT);
    acc_rd  = cmd_ready && (cmd_e == RD);
    acc_wr  = cmd_ready && (cmd_e == WR);
    acc_pre = cmd_ready && (cmd_e == PRE);
    acc_ref = cmd_ready && (cmd_e == REF);
    rtp_t_c = acc_wr ? bk_timing_intf.t_wtp : bk_timing_intf.t_rtp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_open <= 1'b0;
      open_row <= '0;
    end else begin
      row_open <= (state_nxt == ACTIVE);
      if (acc_act) open_row <= cmd_row;
    end
  end

`ifdef SAL_BK_CMD_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                     cmd_err <= 1'b0;
    else if (cmd_valid && !legal_c) cmd_err <= 1'b1;
  end
`else
  logic unused_legal;
  assign unused_legal = legal_c;
`endif

  sal_bk_tcnt #(.TIMING_W(TIMING_W)) u_rcd (
    .clk(clk), .rst_n(rst_n), .load(acc_act), .merge(1'b0),
    .t(bk_timing_intf.t_rcd), .cnt(rcd_cnt), .is_zero(rcd_z));

  sal_bk_tcnt #(.TIMING_W(TIMING_W)) u_ras (
    .clk(clk), .rst_n(rst_n), .load(acc_act), .merge(1'b0),
    .t(bk_timing_intf.t_ras), .cnt(ras_cnt), .is_zero(ras_z));

  sal_bk_tcnt #(.TIMING_W(TIMING_W)) u_rtp (
    .clk(clk), .rst_n(rst_n), .load(acc_rd || acc_wr), .merge(1'b1),
    .t(rtp_t_c), .cnt(rtp_cnt), .is_zero(rtp_z));

  sal_bk_tcnt #(.TIMING_W(TIMING_W)) u_rp (
    .clk(clk), .rst_n(rst_n), .load(acc_pre), .merge(1'b0),
    .t(bk_timing_intf.t_rp), .cnt(rp_cnt), .is_zero(rp_z));

  sal_bk_tcnt #(.TIMING_W(TIMING_W)) u_rfc (
    .clk(clk), .rst_n(rst_n), .load(acc_ref), .merge(1'b0),
    .t(bk_timing_intf.t_rfc), .cnt(rfc_cnt), .is_zero(rfc_z));

  logic unused_cnt;
  assign unused_cnt = ^{rcd_cnt, ras_cnt, rtp_cnt};

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Bench for sal_bank_ctrl: directed table, corner sequences and random traffic against a timestamp model.
module tb_sal_bank_ctrl;
  import sal_bk_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [13:0] cmd_row;
  logic        cmd_ready, act_ready, rdwr_ready, pre_ready, ref_ready, row_open;
  logic [13:0] open_row;
`ifdef SAL_BK_CMD_ERR_EN
  logic        cmd_err;
`endif

  sal_bk_timing_intf #(.TIMING_W(8)) tif ();

  sal_bank_ctrl #(.ROW_W(14), .TIMING_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bk_timing_intf(tif),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_row(cmd_row),
    .cmd_ready(cmd_ready), .act_ready(act_ready), .rdwr_ready(rdwr_ready),
    .pre_ready(pre_ready), .ref_ready(ref_ready), .row_open(row_open),
    .open_row(open_row)
`ifdef SAL_BK_CMD_ERR_EN
    , .cmd_err(cmd_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: bank open/closed plus absolute cycle numbers at which each constraint expires.
  logic        m_open, m_err;
  logic [13:0] m_row;
  int          m_busy, m_rdwr_at, m_pre_at;

  logic s_ready, s_act, s_ref, s_rdwr, s_pre, s_ro, s_err;
  logic [13:0] s_orow;

  typedef struct {
    logic        v;
    logic [2:0]  c;
    logic [13:0] r;
    logic        rdy;
    logic        ro;
    logic        ar;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic v, bk_cmd_t c, logic [13:0] r, logic rdy, logic ro, logic ar);
    vec_t x;
    x.v = v; x.c = 3'(c); x.r = r; x.rdy = rdy; x.ro = ro; x.ar = ar;
    return x;
  endfunction

  function automatic int eff(logic [7:0] t);
    return (t == 8'd0) ? 1 : int'(t);
  endfunction

  function automatic logic m_legal(logic [2:0] c, logic [13:0] r);
    bk_cmd_t ce = bk_cmd_t'(c);
    if (ce == NOP) return 1'b1;
    if (!m_open) return (cyc >= m_busy) && (ce == ACT || ce == REF);
    return ((ce == RD || ce == WR) && r == m_row) || ce == PRE;
  endfunction

  function automatic logic m_act_rdy();
    return !m_open && (cyc >= m_busy);
  endfunction

  function automatic logic m_cmd_rdy(logic v, logic [2:0] c, logic [13:0] r);
    bk_cmd_t ce = bk_cmd_t'(c);
    if (!v || ce == NOP || !m_legal(c, r)) return 1'b0;
    if (ce == RD || ce == WR) return cyc >= m_rdwr_at;
    if (ce == PRE) return cyc >= m_pre_at;
    return m_act_rdy();
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_open = 1'b0; m_row = '0; m_busy = 0; m_rdwr_at = 0; m_pre_at = 0; m_err = 1'b0;
    end else begin
      if (m_cmd_rdy(cmd_valid, cmd, cmd_row)) begin
        case (bk_cmd_t'(cmd))
          ACT: begin
            m_open = 1'b1; m_row = cmd_row;
            m_rdwr_at = cyc + eff(tif.t_rcd);
            m_pre_at  = cyc + eff(tif.t_ras);
          end
          RD:  if (cyc + eff(tif.t_rtp) > m_pre_at) m_pre_at = cyc + eff(tif.t_rtp);
          WR:  if (cyc + eff(tif.t_wtp) > m_pre_at) m_pre_at = cyc + eff(tif.t_wtp);
          PRE: begin m_open = 1'b0; m_busy = cyc + eff(tif.t_rp); end
          REF: m_busy = cyc + eff(tif.t_rfc);
          default: ;
        endcase
      end
      if (cmd_valid && !m_legal(cmd, cmd_row)) m_err = 1'b1;
    end
  endtask

  // One clock: sample and check at negedge, advance the model at posedge, then release for driving.
  task automatic tick();
    @(negedge clk);
    s_ready = cmd_ready; s_act = act_ready; s_ref = ref_ready; s_rdwr = rdwr_ready;
    s_pre = pre_ready; s_ro = row_open; s_orow = open_row; s_err = 1'b0;
`ifdef SAL_BK_CMD_ERR_EN
    s_err = cmd_err;
    chk("cmd_err", s_err, m_err);
`endif
    chk("cmd_ready", s_ready, m_cmd_rdy(cmd_valid, cmd, cmd_row));
    chk("act_ready", s_act, m_act_rdy());
    chk("ref_ready", s_ref, m_act_rdy());
    chk("rdwr_ready", s_rdwr, m_open && (cyc >= m_rdwr_at));
    chk("pre_ready", s_pre, m_open && (cyc >= m_pre_at));
    chk("row_open", s_ro, m_open);
    chk("open_row", s_orow, m_row);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic drive(logic v, bk_cmd_t c, logic [13:0] r);
    cmd_valid = v; cmd = 3'(c); cmd_row = r;
  endtask

  task automatic wait_idle(string name);
    int found = 0;
    for (int k = 0; k < 64; k++) begin
      drive(1'b0, NOP, 14'h0);
      tick();
      if (s_act) begin found = 1; break; end
    end
    chk(name, found, 1);
  endtask

  task automatic hold(bk_cmd_t c, logic [13:0] r, int max, output int n);
    n = -1;
    for (int k = 0; k < max; k++) begin
      drive(1'b1, c, r);
      tick();
      if (s_ready) begin n = k; break; end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    int first;
    logic [2:0] rc;
    logic [13:0] rr;

    tbl[0]  = mk(1'b1, ACT, 14'h12, 1'b1, 1'b0, 1'b1);
    tbl[1]  = mk(1'b1, RD,  14'h12, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, RD,  14'h12, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, RD,  14'h12, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, RD,  14'h12, 1'b1, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, NOP, 14'h12, 1'b0, 1'b1, 1'b0);
    tbl[6]  = mk(1'b1, NOP, 14'h12, 1'b0, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, NOP, 14'h12, 1'b0, 1'b1, 1'b0);
    tbl[8]  = mk(1'b1, RD,  14'h12, 1'b1, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, PRE, 14'h12, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b1, PRE, 14'h12, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, PRE, 14'h12, 1'b1, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, NOP, 14'h0,  1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, NOP, 14'h0,  1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, NOP, 14'h0,  1'b0, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, NOP, 14'h0,  1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, REF, 14'h0,  1'b1, 1'b0, 1'b1);

    tif.t_rcd = 8'd4; tif.t_ras = 8'd10; tif.t_rtp = 8'd3;
    tif.t_wtp = 8'd6; tif.t_rp  = 8'd5;  tif.t_rfc = 8'd20;
    rst_n = 1'b0;
    drive(1'b0, NOP, 14'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_open = 1'b0; m_row = '0; m_busy = 0; m_rdwr_at = 0; m_pre_at = 0; m_err = 1'b0;

    // Reset state.
    tick();
    chk("rst_act_ready", s_act, 1'b1);
    chk("rst_ref_ready", s_ref, 1'b1);
    chk("rst_rdwr_ready", s_rdwr, 1'b0);
    chk("rst_pre_ready", s_pre, 1'b0);
    chk("rst_row_open", s_ro, 1'b0);
    chk("rst_open_row", s_orow, 14'h0);
    chk("rst_cmd_err", s_err, 1'b0);

    // ACT/RD t_rcd, PRE after t_ras and t_rtp, then PRE->REF after t_rp.
    for (int i = 0; i < 17; i++) begin
      cmd_valid = tbl[i].v; cmd = tbl[i].c; cmd_row = tbl[i].r;
      tick();
      chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_row_open", i), s_ro, tbl[i].ro);
      chk($sformatf("tbl%0d_act_ready", i), s_act, tbl[i].ar);
      if (i == 4) chk("tbl_open_row", s_orow, 14'h12);
    end

    // REF accepted at table row 16: ACT ready again t_rfc cycles later.
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      drive(1'b0, NOP, 14'h0);
      tick();
      if (s_act) begin first = k; break; end
    end
    chk("ref_to_act", first, 20);

    // WR then RD: the shorter RD window must not cut short the WR window before PRE.
    tif.t_rcd = 8'd1; tif.t_ras = 8'd1; tif.t_rtp = 8'd2; tif.t_wtp = 8'd6;
    first = -1;
    for (int j = 0; j < 32; j++) begin
      if (j == 0)      drive(1'b1, ACT, 14'h12);
      else if (j == 5) drive(1'b1, WR, 14'h12);
      else if (j == 6) drive(1'b1, RD, 14'h12);
      else if (j >= 7) drive(1'b1, PRE, 14'h12);
      else             drive(1'b0, NOP, 14'h0);
      tick();
      if (j == 0 || j == 5 || j == 6) chk($sformatf("merge_acc%0d", j), s_ready, 1'b1);
      if (j >= 7 && s_ready) begin first = j; break; end
    end
    chk("merge_pre_at", first, 11);

    // Row mismatch and RD in IDLE are stalled (and flagged when the error flag is built in).
    wait_idle("c_idle0");
    drive(1'b1, ACT, 14'h12); tick();
    chk("c_act", s_ready, 1'b1);
    drive(1'b1, RD, 14'h13); tick();
    chk("c_rd_mismatch", s_ready, 1'b0);
    drive(1'b0, NOP, 14'h0); tick();
`ifdef SAL_BK_CMD_ERR_EN
    chk("c_err_set", s_err, 1'b1);
`endif
    hold(PRE, 14'h12, 16, n);
    chk("c_pre_acc", (n >= 0), 1'b1);
    wait_idle("c_idle1");
    drive(1'b1, RD, 14'h12); tick();
    chk("c_rd_idle", s_ready, 1'b0);
    repeat (3) begin drive(1'b0, NOP, 14'h0); tick(); end
`ifdef SAL_BK_CMD_ERR_EN
    chk("c_err_sticky", s_err, 1'b1);
`endif

    // Reset in the middle of a refresh drops the pending t_rfc.
    wait_idle("d_idle");
    tif.t_rfc = 8'd20;
    drive(1'b1, REF, 14'h0); tick();
    chk("d_ref", s_ready, 1'b1);
    repeat (4) begin drive(1'b0, NOP, 14'h0); tick(); end
    chk("d_busy", s_act, 1'b0);
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
    chk("d_act_after_rst", s_act, 1'b1);
    chk("d_ref_after_rst", s_ref, 1'b1);
    chk("d_row_open_after_rst", s_ro, 1'b0);
    chk("d_err_after_rst", s_err, 1'b0);

    // Random traffic, timing changes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: tif.t_rcd = 8'($urandom_range(0, 12));
          1: tif.t_ras = 8'($urandom_range(0, 12));
          2: tif.t_rtp = 8'($urandom_range(0, 12));
          3: tif.t_wtp = 8'($urandom_range(0, 12));
          4: tif.t_rp  = 8'($urandom_range(0, 12));
          default: tif.t_rfc = 8'($urandom_range(0, 12));
        endcase
      end
      rst_n = ($urandom_range(0, 499) != 0);
      n = int'($urandom_range(0, 9));
      if (n == 0)     rc = 3'($urandom_range(0, 7));
      else if (m_open) rc = (n < 4) ? 3'(RD) : (n < 7) ? 3'(WR) : 3'(PRE);
      else             rc = (n < 7) ? 3'(ACT) : 3'(REF);
      if (!m_open || $urandom_range(0, 4) == 0) rr = 14'($urandom_range(16, 19));
      else                                      rr = m_row;
      cmd_valid = ($urandom_range(0, 9) != 0);
      cmd = rc;
      cmd_row = rr;
      tick();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
